// File: rtl/sysarr_skew_feeder.sv
// sysarr_skew_feeder: skews a SIZE-lane word vector into a diagonal wavefront for a systolic-array edge (SKEW_REVERSE_EN flips the skew direction)
module sysarr_skew_feeder #(
  parameter int n    = 31,
  parameter int SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [SIZE*(n+1)-1:0] in_data,
  output logic [SIZE*(n+1)-1:0] out_data,
  output logic [SIZE-1:0]       out_valid,
  output logic                  frame_done
);
  localparam int W  = n + 1;
  localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  assign in_ready = (state != FLUSH) & ~rst;
  assign acc      = in_valid & in_ready;
  // FLUSH lasts SIZE-1 cycles so frame_done lines up with the longest lane
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (acc && in_last) begin
            if (SIZE == 1) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= FLUSH;
              cnt   <= CW'(SIZE > 1 ? SIZE - 2 : 0);
            end
          end else if (acc) begin
            state <= STREAM;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
`ifdef SKEW_REVERSE_EN
    localparam int D = SIZE - i;
`else
    localparam int D = i + 1;
`endif
    logic [W-1:0] dq [D];
    logic [D-1:0] vq;
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < D; k++) dq[k] <= '0;
        vq <= '0;
      end else begin
        dq[0] <= acc ? in_data[i*W +: W] : '0;
        vq[0] <= acc;
        for (int k = 1; k < D; k++) begin
          dq[k] <= dq[k-1];
          vq[k] <= vq[k-1];
        end
      end
    end
    assign out_data[i*W +: W] = dq[D-1];
    assign out_valid[i]       = vq[D-1];
  end
endmodule

// File: tb/tb_sysarr_skew_feeder.sv
// tb_sysarr_skew_feeder: directed table plus randomized frames checked against a history-indexed reference model
module tb_sysarr_skew_feeder;
  localparam int SIZE = 4;
  localparam int W    = 32;
  localparam int DW   = SIZE * W;
`ifdef SKEW_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic          in_ready, frame_done;
  logic [DW-1:0] in_data = '0, out_data;
  logic [SIZE-1:0] out_valid;
  always #5 clk = ~clk;
  sysarr_skew_feeder #(.n(W-1), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done)
  );
  int tests = 0, fails = 0;
  int e = 0, rst_edge = 0, last_fin = -100;
  logic [DW-1:0] hd [64];
  logic          hv [64];
  logic          rdy_s;
  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, a, x, e);
    end
  endtask
  function automatic bit m_ready();
    int d = e + 1 - last_fin;
    return !rst && !(last_fin > rst_edge && d >= 1 && d <= SIZE - 1);
  endfunction
  // One clock: drive, check ready before the edge, update model, check outputs at negedge
  task automatic cyc(input logic r, input logic v, input logic l, input logic [DW-1:0] d);
    logic [DW-1:0]   ed;
    logic [SIZE-1:0] ev;
    bit              acc;
    rst = r; in_valid = v; in_last = l; in_data = d;
    #1;
    rdy_s = m_ready();
    chk("in_ready", DW'(in_ready), DW'(rdy_s));
    @(posedge clk);
    e++;
    if (r) rst_edge = e;
    else begin
      acc = v && rdy_s;
      hd[e%64] = acc ? d : '0;
      hv[e%64] = acc;
      if (acc && l) last_fin = e;
    end
    @(negedge clk);
    ed = '0; ev = '0;
    for (int i = 0; i < SIZE; i++) begin
      int idx = e - (REV ? SIZE - 1 - i : i);
      if (idx > rst_edge) begin
        ed[i*W +: W] = hd[idx%64][i*W +: W];
        ev[i]        = hv[idx%64];
      end
    end
    chk("out_data", out_data, ed);
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("frame_done", DW'(frame_done), DW'(last_fin > rst_edge && e - last_fin == SIZE - 1));
  endtask
  typedef struct {
    logic v, l;
    logic [DW-1:0] d;
    logic rdy;
    logic [DW-1:0] od;
    logic [SIZE-1:0] ov;
    logic fd;
  } vec_t;
  vec_t tbl [5];
  localparam logic [DW-1:0] V4 = 128'h40800000_40400000_40000000_3F800000;
  initial begin
    if (!REV) begin
      tbl[0] = '{1, 1, V4, 1, 128'h3F800000, 4'b0001, 0};
      tbl[1] = '{0, 0, '0, 0, 128'h40000000_00000000, 4'b0010, 0};
      tbl[2] = '{0, 0, '0, 0, 128'h40400000_00000000_00000000, 4'b0100, 0};
      tbl[3] = '{0, 0, '0, 0, 128'h40800000_00000000_00000000_00000000, 4'b1000, 1};
    end else begin
      tbl[0] = '{1, 1, V4, 1, 128'h40800000_00000000_00000000_00000000, 4'b1000, 0};
      tbl[1] = '{0, 0, '0, 0, 128'h40400000_00000000_00000000, 4'b0100, 0};
      tbl[2] = '{0, 0, '0, 0, 128'h40000000_00000000, 4'b0010, 0};
      tbl[3] = '{0, 0, '0, 0, 128'h3F800000, 4'b0001, 1};
    end
    tbl[4] = '{0, 0, '0, 1, '0, 4'b0000, 0};
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, V4);
    cyc(0, 0, 0, '0);
    for (int r = 0; r < 5; r++) begin
      cyc(0, tbl[r].v, tbl[r].l, tbl[r].d);
      chk("tbl_ready", DW'(rdy_s), DW'(tbl[r].rdy));
      chk("tbl_data", out_data, tbl[r].od);
      chk("tbl_valid", DW'(out_valid), DW'(tbl[r].ov));
      chk("tbl_done", DW'(frame_done), DW'(tbl[r].fd));
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, {4{$urandom()}} ^ DW'(k));
    cyc(0, 0, 1, V4);
    cyc(0, 1, 1, V4);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, '0);
    cyc(0, 1, 1, {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, V4);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, '0);
    cyc(0, 1, 0, V4);
    cyc(0, 1, 0, ~V4);
    cyc(1, 1, 1, V4);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, '0);
    for (int k = 0; k < 800; k++)
      cyc($urandom_range(63) == 0, $urandom_range(9) < 7, $urandom_range(3) == 0,
          {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
